reg_wb_arbiter: RTL and testbench
=================================

Name: reg_wb_arbiter

Overview:
- Shares the single write port of the 16x16 register file between two writeback requesters: A (ALU result) and B (load/memory result).
- Grants are round-robin. The write command is registered before it drives the register file.
- Exposes a one-entry forwarding lookup on the in-flight write, so decode can bypass the value before it lands.

Parameters:
DATA_W, 16, width of write data
ADDR_W, 4, width of requester register index (16 registers)
PORT_AW, 16, width of writeReg driven to the register file (index zero-extended)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
hold  in  1  stall: no grants while high
a_valid  in  1  requester A has a write
a_reg  in  ADDR_W  A destination register
a_value  in  DATA_W  A write data
a_ready  out  1  A accepted this cycle
b_valid  in  1  requester B has a write
b_reg  in  ADDR_W  B destination register
b_value  in  DATA_W  B write data
b_ready  out  1  B accepted this cycle
RegWrite  out  1  write enable to register file
writeReg  out  PORT_AW  register index to register file
writeValue  out  DATA_W  data to register file
fwd_addr  in  ADDR_W  forwarding lookup address
fwd_hit  out  1  in-flight write targets fwd_addr
fwd_value  out  DATA_W  in-flight write data
grant_cnt_a  out  8  accepted A writes, wraps at 255->0
grant_cnt_b  out  8  accepted B writes, wraps at 255->0

Behaviour:
- Reset (RST_N low, async): RegWrite=0, writeReg=0, writeValue=0, grant_cnt_a/b=0, priority pointer=PRI_A. Combinational outputs follow from these: a_ready=b_ready=0 while in reset, fwd_hit=0. A reset mid-write drops the in-flight write; RegWrite is 0 from reset assertion, with no partial write.
- Priority pointer is a 2-state FSM:
  - PRI_A: A wins ties.
  - PRI_B: B wins ties.
  - After an A grant, go to PRI_B. After a B grant, go to PRI_A. No grant: hold state.
- Grant logic is combinational, same cycle. hold=1 forces a_ready=b_ready=0.
  - Otherwise, only one valid: grant it.
  - Both valid: grant per pointer.
  - a_ready/b_ready are never both 1.
- Handshake: a write is accepted on a rising edge where valid&ready. Requesters hold valid, reg and value stable until accepted. The ready signals depend on valid; valid must not depend on ready.
- Output stage, registered, 1-cycle latency: on the edge after acceptance, RegWrite=1, writeReg={zeros,reg}, writeValue=value. A cycle with no accept drives RegWrite=0; writeReg/writeValue hold their last values. Back-to-back accepts give RegWrite high on consecutive cycles.
- Forwarding: fwd_hit = RegWrite & (writeReg[ADDR_W-1:0]==fwd_addr). fwd_value = writeValue, valid only when fwd_hit=1.
- Same-register collision (A and B valid, same reg): both are written in grant order on successive cycles. The register's final value is the second-granted writer's. No merging or dropping.
- Counters increment on their own accept. Both are 8-bit and wrap silently.
- hold asserted while requests pending: the pointer does not move. The output drains: the write accepted on the previous edge still appears for one cycle, then RegWrite=0.

Test Plan:
1. Reset with a_valid=1, then release: first edge after RST_N high gives a_ready=1. Next cycle: RegWrite=1, writeReg=0x0003, writeValue=0x1234 for a_reg=3, a_value=0x1234. Pointer goes to PRI_B.
2. A and B valid continuously, regs 1 and 2, values 0xAAAA and 0xBBBB: grants alternate A,B,A,B starting with A after reset. RegWrite high every cycle; writeReg sequence 1,2,1,2. grant_cnt_a=grant_cnt_b=2 after 4 grants.
3. Collision, A and B both on reg 5 with A=0x0001, B=0x0002, pointer PRI_A: writes 0x0001 then 0x0002 to reg 5 on consecutive cycles. fwd_addr=5 shows fwd_hit=1 with fwd_value=0x0001, then 0x0002.
4. hold=1 for 3 cycles with both valid: a_ready=b_ready=0 and RegWrite=0 during hold (after draining one prior write). Pointer unchanged. On release, the tie-winner is unchanged.
5. Reset mid-stream, RST_N low while RegWrite=1: RegWrite falls immediately, without waiting for CLK. Counters read 0. After release, A wins the first tie.
6. Only B valid for 256 accepts: b_ready=1 every cycle. grant_cnt_b wraps to 0x00 and grant_cnt_a stays 0. fwd_hit=0 when fwd_addr differs from b_reg.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU (A) and load (B)
// writeback paths, with a registered write stage and a one-entry forwarding lookup.
module reg_wb_arbiter #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned PORT_AW = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               hold,
  input  logic               a_valid,
  input  logic [ADDR_W-1:0]  a_reg,
  input  logic [DATA_W-1:0]  a_value,
  output logic               a_ready,
  input  logic               b_valid,
  input  logic [ADDR_W-1:0]  b_reg,
  input  logic [DATA_W-1:0]  b_value,
  output logic               b_ready,
  output logic               RegWrite,
  output logic [PORT_AW-1:0] writeReg,
  output logic [DATA_W-1:0]  writeValue,
  input  logic [ADDR_W-1:0]  fwd_addr,
  output logic               fwd_hit,
  output logic [DATA_W-1:0]  fwd_value,
  output logic [7:0]         grant_cnt_a,
  output logic [7:0]         grant_cnt_b
);

  typedef enum logic [0:0] {PriA, PriB} pri_e;

  pri_e               pri_q, pri_d;
  logic               we_q;
  logic [PORT_AW-1:0] wreg_q;
  logic [DATA_W-1:0]  wval_q;
  logic [7:0]         cnt_a_q, cnt_b_q;
  logic [ADDR_W-1:0]  sel_reg;
  logic [DATA_W-1:0]  sel_value;

  // Gating with RST_N keeps both readies low for the whole reset window.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    pri_d   = pri_q;
    if (RST_N && !hold) begin
      if (a_valid && (!b_valid || pri_q == PriA)) begin
        a_ready = 1'b1;
      end else if (b_valid) begin
        b_ready = 1'b1;
      end
    end
    if (a_ready) begin
      pri_d = PriB;
    end else if (b_ready) begin
      pri_d = PriA;
    end
  end

  always_comb begin
    sel_reg   = a_reg;
    sel_value = a_value;
    if (b_ready) begin
      sel_reg   = b_reg;
      sel_value = b_value;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pri_q <= PriA;
    end else begin
      pri_q <= pri_d;
    end
  end

  // Index and data hold their last values when no write is accepted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      we_q   <= 1'b0;
      wreg_q <= '0;
      wval_q <= '0;
    end else begin
      we_q <= a_ready | b_ready;
      if (a_ready || b_ready) begin
        wreg_q <= {{(PORT_AW - ADDR_W){1'b0}}, sel_reg};
        wval_q <= sel_value;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_a_q <= 8'd0;
      cnt_b_q <= 8'd0;
    end else begin
      if (a_ready) cnt_a_q <= cnt_a_q + 8'd1;
      if (b_ready) cnt_b_q <= cnt_b_q + 8'd1;
    end
  end

  assign RegWrite    = we_q;
  assign writeReg    = wreg_q;
  assign writeValue  = wval_q;
  assign fwd_hit     = we_q & (wreg_q[ADDR_W-1:0] == fwd_addr);
  assign fwd_value   = wval_q;
  assign grant_cnt_a = cnt_a_q;
  assign grant_cnt_b = cnt_b_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Scoreboard bench for reg_wb_arbiter: the driver pushes the expected write-stage output for
// every cycle it drives, and a monitor pops and compares after each rising edge.
module tb_reg_wb_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        hold = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [3:0]  a_reg = '0, b_reg = '0, fwd_addr = '0;
  logic [15:0] a_value = '0, b_value = '0;
  logic        a_ready, b_ready, RegWrite, fwd_hit;
  logic [15:0] writeReg, writeValue, fwd_value;
  logic [7:0]  grant_cnt_a, grant_cnt_b;

  typedef struct {
    logic        we;
    logic [3:0]  r;
    logic [15:0] v;
    logic        hit;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail = 0;

  reg_wb_arbiter dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .hold       (hold),
    .a_valid    (a_valid),
    .a_reg      (a_reg),
    .a_value    (a_value),
    .a_ready    (a_ready),
    .b_valid    (b_valid),
    .b_reg      (b_reg),
    .b_value    (b_value),
    .b_ready    (b_ready),
    .RegWrite   (RegWrite),
    .writeReg   (writeReg),
    .writeValue (writeValue),
    .fwd_addr   (fwd_addr),
    .fwd_hit    (fwd_hit),
    .fwd_value  (fwd_value),
    .grant_cnt_a(grant_cnt_a),
    .grant_cnt_b(grant_cnt_b)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // exp_g: 0 = no grant, 1 = A granted, 2 = B granted.
  task automatic step(input logic av, input logic [3:0] ar, input logic [15:0] avl,
                      input logic bv, input logic [3:0] br, input logic [15:0] bvl,
                      input logic hd, input logic [3:0] fa, input int exp_g);
    exp_t e;
    @(negedge CLK);
    a_valid = av; a_reg = ar; a_value = avl;
    b_valid = bv; b_reg = br; b_value = bvl;
    hold = hd; fwd_addr = fa;
    #1;
    chk("a_ready", a_ready, exp_g == 1);
    chk("b_ready", b_ready, exp_g == 2);
    e.we  = (exp_g != 0);
    e.r   = (exp_g == 2) ? br : ar;
    e.v   = (exp_g == 2) ? bvl : avl;
    e.hit = e.we && (e.r == fa);
    q.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 0);
  endtask

  task automatic do_reset();
    q.delete();
    RST_N = 1'b0;
    #1;
    chk("rst RegWrite", RegWrite, 0);
    chk("rst writeReg", writeReg, 0);
    chk("rst writeValue", writeValue, 0);
    chk("rst cnt_a", grant_cnt_a, 0);
    chk("rst cnt_b", grant_cnt_b, 0);
    chk("rst a_ready", a_ready, 0);
    chk("rst fwd_hit", fwd_hit, 0);
    @(posedge CLK);
    #2;
    RST_N = 1'b1;
  endtask

  // Monitor: one expected entry per driven cycle, compared after the edge that registers it.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #2;
      if (RST_N && q.size() > 0) begin
        e = q.pop_front();
        chk("RegWrite", RegWrite, e.we);
        chk("fwd_hit", fwd_hit, e.hit);
        if (e.we) begin
          chk("writeReg", writeReg, {12'h000, e.r});
          chk("writeValue", writeValue, e.v);
        end
        if (e.hit) chk("fwd_value", fwd_value, e.v);
      end
    end
  end

  initial begin
    // 1: A valid through reset is granted on the first edge after release.
    a_valid = 1'b1; a_reg = 4'd3; a_value = 16'h1234;
    do_reset();
    step(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'h0, 1'b0, 4'd3, 1);
    idle();
    chk("t1 cnt_a", grant_cnt_a, 1);
    step(1'b1, 4'd1, 16'hAAAA, 1'b1, 4'd2, 16'hBBBB, 1'b0, 4'd0, 2);
    idle();

    // 2: continuous ties alternate starting with A.
    do_reset();
    step(1'b1, 4'd1, 16'hAAAA, 1'b1, 4'd2, 16'hBBBB, 1'b0, 4'd2, 1);
    step(1'b1, 4'd1, 16'hAAAA, 1'b1, 4'd2, 16'hBBBB, 1'b0, 4'd2, 2);
    step(1'b1, 4'd1, 16'hAAAA, 1'b1, 4'd2, 16'hBBBB, 1'b0, 4'd2, 1);
    step(1'b1, 4'd1, 16'hAAAA, 1'b1, 4'd2, 16'hBBBB, 1'b0, 4'd2, 2);
    idle();
    chk("t2 cnt_a", grant_cnt_a, 2);
    chk("t2 cnt_b", grant_cnt_b, 2);

    // 3: same-register collision, both written in grant order.
    step(1'b1, 4'd5, 16'h0001, 1'b1, 4'd5, 16'h0002, 1'b0, 4'd5, 1);
    step(1'b0, 4'd5, 16'h0001, 1'b1, 4'd5, 16'h0002, 1'b0, 4'd5, 2);
    idle();

    // 4: hold freezes grants and the pointer; the prior write still drains.
    step(1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b0, 4'd1, 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b1, 4'd1, 0);
    end
    step(1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b0, 4'd1, 2);
    step(1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b0, 4'd1, 1);

    // 5: asynchronous reset while a write is in flight.
    step(1'b1, 4'd6, 16'h6666, 1'b1, 4'd7, 16'h7777, 1'b0, 4'd7, 2);
    @(posedge CLK);
    #3;
    chk("t5 RegWrite before rst", RegWrite, 1);
    RST_N = 1'b0;
    #1;
    chk("t5 RegWrite async", RegWrite, 0);
    chk("t5 cnt_a", grant_cnt_a, 0);
    chk("t5 cnt_b", grant_cnt_b, 0);
    chk("t5 b_ready in rst", b_ready, 0);
    q.delete();
    @(posedge CLK);
    #2;
    RST_N = 1'b1;
    step(1'b1, 4'd6, 16'h6666, 1'b1, 4'd7, 16'h7777, 1'b0, 4'd0, 1);
    idle();

    // 6: 256 B-only accepts wrap grant_cnt_b; forwarding misses on a different address.
    a_valid = 1'b0; b_valid = 1'b0;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 16'(i * 3 + 1), 1'b0, 4'd9, 2);
      if (i == 255) chk("t6 cnt_b 255", grant_cnt_b, 255);
    end
    idle();
    chk("t6 cnt_b wrap", grant_cnt_b, 0);
    chk("t6 cnt_a", grant_cnt_a, 0);

    @(posedge CLK);
    #3;
    chk("scoreboard drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
